// File: rtl/bitcnt_pkg.sv
// Shared types and helpers for the bitcnt issue/capture stage and its core.
// func encoding: bit 0 selects 32-bit W mode, bits [2:1] select the operation.
// Pure declarations, no logic.
package bitcnt_pkg;

  localparam int DATA_W = 64;
  localparam int HALF_W = 32;

  typedef enum logic [1:0] {
    FUNC_CLZ  = 2'd0,
    FUNC_CTZ  = 2'd1,
    FUNC_CPOP = 2'd2,
    FUNC_RSVD = 2'd3
  } func_e;

  function automatic logic is_w(input logic [2:0] func);
    return func[0];
  endfunction

  function automatic logic is_rsvd(input logic [2:0] func);
    return func[2:1] == FUNC_RSVD;
  endfunction

  function automatic func_e func_op(input logic [2:0] func);
    return func_e'(func[2:1]);
  endfunction

endpackage

// File: rtl/bitcnt.sv
// Combinational bitcnt core: CLZ / CTZ / CPOP over 64 bits or the low 32 bits (W).
// Latency: 0 cycles, purely combinational.
// No flow control; the reserved opcode yields 0.
module bitcnt
  import bitcnt_pkg::*;
(
  input  logic [DATA_W-1:0] din_data,
  input  logic              din_w,
  input  func_e             din_op,
  output logic [DATA_W-1:0] dout_data
);

  logic [DATA_W-1:0] w_src;
  logic [6:0]        w_clz;
  logic [6:0]        w_ctz;
  logic [6:0]        w_pop;
  logic [6:0]        w_cnt;

  // W mode only ever looks at the low half.
  assign w_src = din_w ? {{HALF_W{1'b0}}, din_data[HALF_W-1:0]} : din_data;

  // Leading zeros: scanning upward, the highest set bit is the last to write.
  always_comb begin
    w_clz = 7'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (w_src[i]) w_clz = 7'(DATA_W - 1 - i);
    end
  end

  // Trailing zeros: scanning downward, the lowest set bit is the last to write.
  always_comb begin
    w_ctz = 7'(DATA_W);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (w_src[i]) w_ctz = 7'(i);
    end
  end

  // Population count.
  always_comb begin
    w_pop = 7'd0;
    for (int i = 0; i < DATA_W; i++) begin
      w_pop = w_pop + {6'd0, w_src[i]};
    end
  end

  // Operation select; W-mode CLZ discounts the zeroed upper half, W-mode CTZ of zero is 32.
  always_comb begin
    w_cnt = 7'd0;
    case (din_op)
      FUNC_CLZ:  w_cnt = din_w ? (w_clz - 7'(HALF_W)) : w_clz;
      FUNC_CTZ:  w_cnt = (din_w && (w_ctz == 7'(DATA_W))) ? 7'(HALF_W) : w_ctz;
      FUNC_CPOP: w_cnt = w_pop;
      default:   w_cnt = 7'd0;
    endcase
  end

  assign dout_data = {{(DATA_W-7){1'b0}}, w_cnt};

endmodule

// File: rtl/bitcnt_skid.sv
// One-entry skid buffer holding an accepted {operand, func} while the output is stalled.
// Latency: entry readable the cycle after push.
// Pushed only when the stage output cannot take the request; popped when it drains.
module bitcnt_skid
  import bitcnt_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  input  logic [2:0]        i_func,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data,
  output logic [2:0]        o_func
);

  logic              r_vld;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_func;

  // Single entry: push fills it, pop empties it; reset discards contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_func <= '0;
    end else if (i_push) begin
      r_vld  <= 1'b1;
      r_data <= i_data;
      r_func <= i_func;
    end else if (i_pop) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_func = r_func;

endmodule

// File: rtl/bitcnt_stage.sv
// Valid/ready issue+capture stage around the bitcnt core, with a saturating done counter.
// Latency: 1 cycle; full throughput. BITCNT_STAGE_SKID_EN adds a 1-entry skid.
// Default: in_ready = !out_valid || out_ready; with skid: in_ready is a flop (= skid empty).
module bitcnt_stage
  import bitcnt_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              w_out_free;
  logic              w_out_hs;
  logic              w_in_acc;
  logic              w_src_vld;
  logic              w_load;
  logic [DATA_W-1:0] w_src_data;
  logic [2:0]        w_src_func;
  logic [DATA_W-1:0] w_core_din;
  logic [DATA_W-1:0] w_core_dout;

  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_err;
  logic [CNT_W-1:0]  r_done_cnt;

  // Output register can take a new result if empty or draining this cycle.
  assign w_out_free = !r_out_vld || out_ready;
  assign w_out_hs   = r_out_vld && out_ready;

`ifdef BITCNT_STAGE_SKID_EN
  logic              r_in_rdy;
  logic              w_skid_vld;
  logic              w_skid_push;
  logic              w_skid_pop;
  logic [DATA_W-1:0] w_skid_data;
  logic [2:0]        w_skid_func;

  assign in_ready    = r_in_rdy && !reset;
  assign w_in_acc    = in_valid && in_ready;
  assign w_skid_push = w_in_acc && !w_out_free;
  assign w_skid_pop  = w_skid_vld && w_out_free;

  bitcnt_skid u_skid (
    .clock  (clock),
    .reset  (reset),
    .i_push (w_skid_push),
    .i_pop  (w_skid_pop),
    .i_data (in_data),
    .i_func (in_func),
    .o_vld  (w_skid_vld),
    .o_data (w_skid_data),
    .o_func (w_skid_func)
  );

  // in_ready mirrors next-cycle skid emptiness so it never depends on out_ready combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_rdy <= 1'b1;
    end else begin
      r_in_rdy <= !((w_skid_vld || w_in_acc) && !w_out_free);
    end
  end

  // The older skid entry always goes to the core first; in_ready is low while it is held.
  assign w_src_vld  = w_skid_vld || w_in_acc;
  assign w_src_data = w_skid_vld ? w_skid_data : in_data;
  assign w_src_func = w_skid_vld ? w_skid_func : in_func;
`else
  assign in_ready   = w_out_free && !reset;
  assign w_in_acc   = in_valid && in_ready;
  assign w_src_vld  = w_in_acc;
  assign w_src_data = in_data;
  assign w_src_func = in_func;
`endif

  assign w_load     = w_src_vld && w_out_free;
  assign w_core_din = is_w(w_src_func) ? {{HALF_W{1'b0}}, w_src_data[HALF_W-1:0]} : w_src_data;

  bitcnt u_core (
    .din_data  (w_core_din),
    .din_w     (is_w(w_src_func)),
    .din_op    (func_op(w_src_func)),
    .dout_data (w_core_dout)
  );

  // Output register: load on a new result (replacing a draining one), clear when drained, else hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_err  <= 1'b0;
    end else if (w_load) begin
      r_out_vld  <= 1'b1;
      r_out_data <= is_rsvd(w_src_func) ? '0 : w_core_dout;
      r_out_err  <= is_rsvd(w_src_func);
    end else if (out_ready) begin
      r_out_vld  <= 1'b0;
    end
  end

  // Count output handshakes, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_done_cnt <= '0;
    end else if (w_out_hs && (r_done_cnt != CNT_MAX)) begin
      r_done_cnt <= r_done_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_vld;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_bitcnt_stage.sv
// Bench for bitcnt_stage: table vectors, backpressure/saturation/reset sequences, random traffic.
// A CNT_W=2 twin shares all inputs to exercise counter saturation alongside the main instance.
// Works with or without BITCNT_STAGE_SKID_EN.
module tb_bitcnt_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic [2:0]  in_func = 3'd0;

  logic        in_ready, out_valid, out_err;
  logic [63:0] out_data;
  logic [15:0] done_cnt;
  logic        in_ready2, out_valid2, out_err2;
  logic [63:0] out_data2;
  logic [1:0]  done_cnt2;

  bitcnt_stage #(.CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_func(in_func), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .done_cnt(done_cnt)
  );

  bitcnt_stage #(.CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_func(in_func), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_err(out_err2), .done_cnt(done_cnt2)
  );

  always #5 clock = ~clock;

`ifdef BITCNT_STAGE_SKID_EN
  localparam int MAX_INFLIGHT = 2;
`else
  localparam int MAX_INFLIGHT = 1;
`endif

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {err, result} from the operation definitions.
  function automatic logic [64:0] ref_res(input logic [63:0] d, input logic [2:0] f);
    int          n;
    int          r;
    logic [63:0] v;
    n = f[0] ? 32 : 64;
    v = f[0] ? {32'd0, d[31:0]} : d;
    r = 0;
    case (f[2:1])
      2'd0:    while (r < n && !v[n-1-r]) r++;
      2'd1:    while (r < n && !v[r]) r++;
      2'd2:    r = $countones(v);
      default: return {1'b1, 64'd0};
    endcase
    return {1'b0, 64'(r)};
  endfunction

  function automatic logic [63:0] sat(input int v, input int m);
    return 64'((v > m) ? m : v);
  endfunction

  // Scoreboard: accepted requests queue in order; every output handshake must match the head.
  logic [64:0] exp_q[$];
  int          hs_total = 0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_data = 64'd0;
  logic        prev_err = 1'b0;

  always @(negedge clock) begin
    logic [64:0] e;
    if (reset) begin
      chk_b("rst_no_accept", in_ready, 1'b0);
      exp_q.delete();
      hs_total  = 0;
      prev_hold = 1'b0;
    end else begin
      chk("done_cnt", 64'(done_cnt), sat(hs_total, 65535));
      chk("done_cnt_sat2", 64'(done_cnt2), sat(hs_total, 3));
      chk("twin_data", out_data2, out_data);
      chk("twin_flags", {61'd0, in_ready2, out_valid2, out_err2}, {61'd0, in_ready, out_valid, out_err});
`ifndef BITCNT_STAGE_SKID_EN
      chk_b("in_ready_comb", in_ready, !out_valid || out_ready);
`endif
      if (prev_hold) begin
        chk_b("hold_vld", out_valid, 1'b1);
        chk("hold_data", out_data, prev_data);
        chk_b("hold_err", out_err, prev_err);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_b("spurious_out", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", out_data, e[63:0]);
          chk_b("sb_err", out_err, e[64]);
        end
        hs_total++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_res(in_data, in_func));
        chk_b("inflight_bound", exp_q.size() <= MAX_INFLIGHT, 1'b1);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_err  = out_err;
    end
  end

  typedef struct {
    logic [63:0] data;
    logic [2:0]  func;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vec[NV];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    logic acc2;

    vec[0]  = '{64'h0000_0001_0000_0000, 3'b000, 64'd31, 1'b0};
    vec[1]  = '{64'hFFFF_FFFF_0000_0000, 3'b011, 64'd32, 1'b0};
    vec[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 64'd0,  1'b1};
    vec[3]  = '{64'h0,                   3'b000, 64'd64, 1'b0};
    vec[4]  = '{64'h0,                   3'b001, 64'd32, 1'b0};
    vec[5]  = '{64'h0,                   3'b010, 64'd64, 1'b0};
    vec[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 64'd64, 1'b0};
    vec[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 3'b101, 64'd32, 1'b0};
    vec[8]  = '{64'h8000_0000_0000_0000, 3'b000, 64'd0,  1'b0};
    vec[9]  = '{64'hFFFF_FFFF_0000_0001, 3'b011, 64'd0,  1'b0};
    vec[10] = '{64'hFFFF_FFFF_8000_0000, 3'b001, 64'd0,  1'b0};
    vec[11] = '{64'h0000_0000_0000_00FF, 3'b100, 64'd8,  1'b0};
    vec[12] = '{64'h0000_0001_0000_0000, 3'b001, 64'd32, 1'b0};
    vec[13] = '{64'h1234_5678_0000_0000, 3'b111, 64'd0,  1'b1};

    do_reset();
    @(negedge clock);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'd0);
    chk_b("rst_out_err", out_err, 1'b0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    chk_b("rst_in_ready", in_ready, 1'b1);
    tick();

    // Table vectors: one request each, checked one cycle later.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i].data;
      in_func  = vec[i].func;
      @(negedge clock);
      chk_b("tv_in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      @(negedge clock);
      chk_b("tv_out_valid", out_valid, 1'b1);
      chk("tv_out_data", out_data, vec[i].exp_data);
      chk_b("tv_out_err", out_err, vec[i].exp_err);
      chk("tv_done_cnt", 64'(done_cnt), 64'(i));
      tick();
    end

    // Backpressure: CPOP 0xFF then 0xF with a 3-cycle stall; expect 8 then 4.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hFF;
    in_func   = 3'b100;
    @(negedge clock);
    chk_b("bp_acc1", in_ready, 1'b1);
    tick();
    in_data = 64'hF;
    acc2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk_b("bp_stall_vld", out_valid, 1'b1);
      chk("bp_stall_data", out_data, 64'd8);
      if (in_valid && in_ready) acc2 = 1'b1;
      tick();
      if (acc2) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_first", out_data, 64'd8);
    if (in_valid && in_ready) acc2 = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_b("bp_acc2", acc2, 1'b1);
    @(negedge clock);
    chk_b("bp_second_vld", out_valid, 1'b1);
    chk("bp_second", out_data, 64'd4);
    tick();
    @(negedge clock);
    chk_b("bp_no_dup", out_valid, 1'b0);
    tick();

    // Saturation: 5 back-to-back handshakes -> CNT_W=2 twin reads 3.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hF0F0;
    in_func   = 3'b100;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    chk("sat_cnt2", 64'(done_cnt2), 64'd3);
    chk("sat_cnt16", 64'(done_cnt), 64'd5);
    tick();

    // Reset while a result is held: discarded, not counted.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h5;
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    chk_b("rmid_held", out_valid, 1'b1);
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk_b("rmid_out_valid", out_valid, 1'b0);
    chk("rmid_done_cnt", 64'(done_cnt), 64'd0);
    chk("rmid_done_cnt2", 64'(done_cnt2), 64'd0);
    chk_b("rmid_in_ready", in_ready, 1'b1);
    tick();

    // Random traffic with occasional reset, scored by the monitor.
    for (int c = 0; c < 3000; c++) begin
      reset     = (c % 997) == 996;
      in_valid  = $urandom_range(0, 9) < 6;
      out_ready = $urandom_range(0, 9) < 7;
      case ($urandom_range(0, 4))
        0:       in_data = {$urandom, $urandom};
        1:       in_data = 64'd1 << $urandom_range(0, 63);
        2:       in_data = 64'd0;
        3:       in_data = ~(64'd1 << $urandom_range(0, 63));
        default: in_data = {$urandom, $urandom} & ({$urandom, $urandom} >> $urandom_range(0, 63));
      endcase
      in_func = 3'($urandom_range(0, 7));
      tick();
    end
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clock);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk_b("drain_out_valid", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
